// File: rtl/io_in_cond.sv
// Switch/button input conditioning: two-flop synchronisers, per-bit debounce
// counters, and registered press/release pulses for the buttons.

module io_in_cond_chan #(
  parameter int W      = 1,
  parameter int DB_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] level
);
  localparam int           CW   = $clog2(DB_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [W-1:0]  ff1;
  logic [W-1:0]  ff2;
  logic [W-1:0]  s;
  logic [CW-1:0] cnt [W];

  // NOTE: state uses non-blocking assignments so every flop samples
  // pre-edge values; the ff1 -> ff2 chain relies on that.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff1 <= '0;
      ff2 <= '0;
      s   <= '0;
      // NOTE: the counter array is reset on purpose so a reset mid-debounce
      // throws away the partial count instead of resuming it.
      for (int i = 0; i < W; i++) cnt[i] <= '0;
    end else begin
      ff1 <= raw;
      ff2 <= ff1;
      for (int i = 0; i < W; i++) begin
        if (ff2[i] == s[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          s[i]   <= ff2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + ONE;
        end
      end
    end
  end

  assign level = s;
endmodule

module io_in_cond #(
  parameter int SW_W           = 32,
  parameter int BTN_W          = 4,
  parameter int SW_DB_CYC      = 4,
  parameter int BTN_DB_CYC     = 500000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw_raw,
  input  logic [BTN_W-1:0] btn_raw,
  output logic [SW_W-1:0]  io_sw,
  output logic [BTN_W-1:0] io_btn,
  output logic [BTN_W-1:0] btn_press,
  output logic [BTN_W-1:0] btn_release
);
  logic [BTN_W-1:0] btn_cond;
  logic [BTN_W-1:0] btn_s_d;

  // Buttons become active-high before the first sync flop.
  assign btn_cond = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  io_in_cond_chan #(.W(SW_W), .DB_CYC(SW_DB_CYC)) u_sw (
    .clk   (clk),
    .rst   (rst),
    .raw   (sw_raw),
    .level (io_sw)
  );

  io_in_cond_chan #(.W(BTN_W), .DB_CYC(BTN_DB_CYC)) u_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_cond),
    .level (io_btn)
  );

  // Pulses are registered, so they land in the cycle after io_btn moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s_d     <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_s_d     <= io_btn;
      btn_press   <= io_btn & ~btn_s_d;
      btn_release <= ~io_btn & btn_s_d;
    end
  end
endmodule

// File: tb/tb_io_in_cond.sv
// Self-checking bench for io_in_cond: vector table, hand-timed corner cases,
// and random stimulus compared against a run-length debounce model.

module tb_io_in_cond;
  localparam int SW_W  = 32;
  localparam int BTN_W = 4;
  localparam int SW_DB = 4;
  localparam int BT_DB = 8;
  localparam int N     = SW_W + BTN_W;

  logic             clk;
  logic             rst;
  logic [SW_W-1:0]  sw_raw;
  logic [BTN_W-1:0] btn_raw;
  logic [SW_W-1:0]  io_sw;
  logic [BTN_W-1:0] io_btn;
  logic [BTN_W-1:0] btn_press;
  logic [BTN_W-1:0] btn_release;

  int n_checks = 0;
  int n_fail   = 0;

  io_in_cond #(
    .SW_W(SW_W), .BTN_W(BTN_W), .SW_DB_CYC(SW_DB), .BTN_DB_CYC(BT_DB),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .io_sw(io_sw), .io_btn(io_btn), .btn_press(btn_press), .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a bit adopts a new level once its synchronised sample has
  // shown that level for DB consecutive cycles (tracked as a run length).
  typedef struct {
    logic [N-1:0]     p1;
    logic [N-1:0]     p2;
    logic [N-1:0]     s;
    logic [N-1:0]     s_prev;
    logic [N-1:0]     last;
    int               run [N];
    logic [BTN_W-1:0] press;
    logic [BTN_W-1:0] rel;
  } model_t;

  model_t m;
  bit     model_valid = 1'b0;

  function automatic model_t model_next(input model_t cur, input logic r, input logic [N-1:0] cond);
    model_t nx;
    logic   smp;
    int     db;
    nx = cur;
    if (r) begin
      nx.p1 = '0; nx.p2 = '0; nx.s = '0; nx.s_prev = '0; nx.last = '0;
      nx.press = '0; nx.rel = '0;
      for (int i = 0; i < N; i++) nx.run[i] = 0;
      return nx;
    end
    nx.press  = cur.s[N-1:SW_W] & ~cur.s_prev[N-1:SW_W];
    nx.rel    = ~cur.s[N-1:SW_W] & cur.s_prev[N-1:SW_W];
    nx.s_prev = cur.s;
    for (int i = 0; i < N; i++) begin
      smp = cur.p2[i];
      db  = (i < SW_W) ? SW_DB : BT_DB;
      if (cur.run[i] > 0 && smp == cur.last[i])
        nx.run[i] = (cur.run[i] < 1000) ? cur.run[i] + 1 : cur.run[i];
      else
        nx.run[i] = 1;
      nx.last[i] = smp;
      if (smp != cur.s[i] && nx.run[i] >= db) nx.s[i] = smp;
    end
    nx.p2 = cur.p1;
    nx.p1 = cond;
    return nx;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, rst, {~btn_raw, sw_raw});
    if (rst) model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_io_sw", 64'(io_sw), 64'(m.s[SW_W-1:0]));
      check("model_io_btn", 64'(io_btn), 64'(m.s[N-1:SW_W]));
      check("model_press", 64'(btn_press), 64'(m.press));
      check("model_release", 64'(btn_release), 64'(m.rel));
    end
  end

  typedef struct {
    logic [SW_W-1:0]  sw;
    logic [BTN_W-1:0] btn;
    logic [SW_W-1:0]  exp_sw;
    logic [BTN_W-1:0] exp_btn;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n_press, n_rel, n_tr, bad;
    logic prev;

    vecs[0] = '{32'h0000_0000, 4'hF, 32'h0000_0000, 4'h0};
    vecs[1] = '{32'hFFFF_FFFF, 4'h0, 32'hFFFF_FFFF, 4'hF};
    vecs[2] = '{32'h1234_5678, 4'hA, 32'h1234_5678, 4'h5};
    vecs[3] = '{32'h8000_0001, 4'h6, 32'h8000_0001, 4'h9};
    vecs[4] = '{32'hDEAD_BEEF, 4'hE, 32'hDEAD_BEEF, 4'h1};

    // Reset with buttons released: everything stays at zero.
    rst = 1'b1; sw_raw = '0; btn_raw = 4'hF;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("reset_outputs", 64'({io_sw, io_btn, btn_press, btn_release}), 64'd0);
    end
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check("post_reset_outputs", 64'({io_sw, io_btn, btn_press, btn_release}), 64'd0);
    end

    // Vector table: each entry held long enough to settle and its pulses to clear.
    for (int v = 0; v < 5; v++) begin
      sw_raw = vecs[v].sw; btn_raw = vecs[v].btn;
      repeat (12) @(negedge clk);
      check("vec_io_sw", 64'(io_sw), 64'(vecs[v].exp_sw));
      check("vec_io_btn", 64'(io_btn), 64'(vecs[v].exp_btn));
      check("vec_pulses_idle", 64'({btn_press, btn_release}), 64'd0);
    end

    // Clean press of button 0 followed by a long hold.
    sw_raw = '0; btn_raw = 4'hF;
    repeat (20) @(negedge clk);
    btn_raw[0] = 1'b0;
    n_press = 0; n_rel = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 9)  check("press_io_btn_before", 64'(io_btn[0]), 64'd0);
      if (j == 10) check("press_io_btn_after", 64'(io_btn[0]), 64'd1);
      if (j == 10) check("press_pulse_early", 64'(btn_press[0]), 64'd0);
      if (j == 11) check("press_pulse", 64'(btn_press[0]), 64'd1);
      if (j == 12) check("press_pulse_end", 64'(btn_press[0]), 64'd0);
      n_press += int'(btn_press[0]);
      n_rel   += int'(btn_release[0]);
    end
    check("press_count_long_hold", 64'(n_press), 64'd1);
    check("press_no_release", 64'(n_rel), 64'd0);
    btn_raw = 4'hF;
    repeat (20) @(negedge clk);

    // Glitches on button 1 shorter than the debounce window.
    foreach (vecs[v]) begin end
    for (int g = 0; g < 2; g++) begin
      bad = 0;
      btn_raw[1] = 1'b0;
      repeat ((g == 0) ? 5 : 7) begin
        @(negedge clk);
        bad += int'(io_btn[1] | btn_press[1] | btn_release[1]);
      end
      btn_raw[1] = 1'b1;
      repeat (20) begin
        @(negedge clk);
        bad += int'(io_btn[1] | btn_press[1] | btn_release[1]);
      end
      check((g == 0) ? "glitch_5" : "glitch_7", 64'(bad), 64'd0);
    end

    // Bouncing switch 3: 1/0/1/0 in 2-cycle steps, then held at 1.
    prev = io_sw[3]; n_tr = 0;
    for (int p = 0; p < 4; p++) begin
      sw_raw[3] = (p % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        if (io_sw[3] !== prev) n_tr++;
        prev = io_sw[3];
      end
    end
    sw_raw[3] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 5) check("bounce_before", 64'(io_sw[3]), 64'd0);
      if (j == 6) check("bounce_after", 64'(io_sw[3]), 64'd1);
      if (io_sw[3] !== prev) n_tr++;
      prev = io_sw[3];
    end
    check("bounce_transitions", 64'(n_tr), 64'd1);

    // Simultaneous switch word change, button 2 release and button 3 press.
    sw_raw = '0; btn_raw = 4'b1011;
    repeat (20) @(negedge clk);
    sw_raw = 32'hA5A5_0F0F; btn_raw = 4'b0111;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 5)  check("simul_sw_before", 64'(io_sw), 64'd0);
      if (j == 6)  check("simul_sw_after", 64'(io_sw), 64'hA5A5_0F0F);
      if (j == 9)  check("simul_btn_before", 64'(io_btn), 64'h4);
      if (j == 10) check("simul_btn_after", 64'(io_btn), 64'h8);
      if (j == 11) check("simul_press", 64'(btn_press), 64'h8);
      if (j == 11) check("simul_release", 64'(btn_release), 64'h4);
      if (j == 12) check("simul_pulses_end", 64'({btn_press, btn_release}), 64'd0);
    end

    // Reset during a button-0 count of 5; the count must restart afterwards.
    sw_raw = '0; btn_raw = 4'hF;
    repeat (20) @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", 64'({io_btn, btn_press, btn_release}), 64'd0);
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 9)  check("midreset_before", 64'(io_btn[0]), 64'd0);
      if (j == 10) check("midreset_after", 64'(io_btn[0]), 64'd1);
      if (j == 10) check("midreset_no_early_pulse", 64'(btn_press[0]), 64'd0);
      if (j == 11) check("midreset_pulse", 64'(btn_press[0]), 64'd1);
    end

    // Random traffic, with occasional resets, checked by the model each cycle.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2) == 0) sw_raw = sw_raw ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0) btn_raw[$urandom_range(0, BTN_W - 1)] ^= 1'b1;
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
